rtc_write_cycle: RTL
====================

Name: rtc_write_cycle

Overview:
Generates one complete write cycle on the RTC multiplexed address/data bus (A/D, CS, WR, RD). Each cycle has an address phase followed by a data phase. It is the writer counterpart of the existing RTC read-cycle counter, and the top-level controller uses it to program RTC registers (time set, control). The block latches an address/data pair on a start request and drives the bus with programmable setup, pulse, hold and gap timing, counted in clk cycles.

Parameters:
T_SETUP, 2, cycles that CS/A-D/bus are stable before WR falls; legal range 1..63.
T_PULSE, 4, cycles WR is held low per phase; legal range 1..63.
T_HOLD, 2, cycles CS/A-D/bus are held after WR rises; legal range 1..63.
T_GAP, 2, cycles CS is high between the address phase and the data phase; legal range 1..63.

Ports:
clk  in  1  system clock; the single clock domain.
reset  in  1  asynchronous reset, active-low: the block is in reset while reset=0.
start  in  1  request pulse; sampled only in IDLE.
addr  in  8  RTC register address; latched on accepted start.
data  in  8  value to write; latched on accepted start.
cs_n  out  1  chip select, active-low.
ad_n  out  1  A/D select: 0 = address phase, 1 = data phase.
wr_n  out  1  write strobe, active-low.
rd_n  out  1  read strobe; held constant at 1.
bus_out  out  8  value driven onto the AD bus.
bus_oe  out  1  tri-state enable for bus_out; the pad is driven when this is 1.
busy  out  1  high in every state except IDLE.
done  out  1  single-cycle pulse when the cycle completes.

Behaviour:
- All outputs are registered, decoded from the next state and the counter.
- Reset values: cs_n=1, ad_n=1, wr_n=1, rd_n=1, bus_out=0, bus_oe=0, busy=0, done=0, state=IDLE, counter=0, latched addr/data=0.
- States, in order: IDLE, A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD, DONE.
- Phase counter: 6-bit down-counter, loaded with (param-1) on state entry. The state advances when the counter reaches 0, so each state lasts exactly param cycles.
- IDLE: if start=1 at a rising edge, latch addr/data and go to A_SETUP. Otherwise stay.
- A_SETUP/A_PULSE/A_HOLD: cs_n=0, ad_n=0, bus_out=addr latch, bus_oe=1. wr_n=0 only in A_PULSE.
- GAP: cs_n=1, ad_n=1, wr_n=1, bus_oe=0.
- D_SETUP/D_PULSE/D_HOLD: cs_n=0, ad_n=1, bus_out=data latch, bus_oe=1. wr_n=0 only in D_PULSE.
- DONE: lasts 1 cycle. done=1, busy=1, all strobes inactive, bus_oe=0. Then go to IDLE.
- Timing with defaults, taking the start-accept edge as edge 0 and cycle n as the period after edge n-1:
  - cs_n=0 in cycles 1-8 and 11-18.
  - wr_n=0 in cycles 3-6 and 13-16.
  - ad_n=0 in cycles 1-8.
  - bus_oe=1 in cycles 1-8 and 11-18.
  - done=1 in cycle 19.
  - busy=1 in cycles 1-19.
  - The earliest next accepted start is at the edge ending cycle 20 (the first IDLE cycle).
- start while busy=1: ignored, with no queueing. addr/data changes while busy are ignored, because the latched copies are used.
- start held high continuously: a new cycle begins on every return to IDLE.
- bus_out changes only while wr_n=1. WR never falls in the same cycle as a CS or A/D transition.
- Reset asserted mid-cycle: outputs go to reset values immediately (asynchronously). No partial cycle resumes after release.
- Parameters are elaborated as given. A value of 0 is illegal; the implementation flags it with an elaboration-time check.

Decomposition:
- Shared package (rtc_bus_pkg): state encoding localparams, default timing constants, and bus idle levels (CS/WR/RD inactive = 1). The read-cycle counter reuses the same package.
- One sub-module: rtc_phase_timer, a 6-bit loadable down-counter with load, load value and a zero flag. The FSM instantiates it once.

Test Plan:
1. Reset: hold reset=0 for 5 cycles with start=1 → cs_n=wr_n=rd_n=ad_n=1, bus_oe=0, busy=0, done=0 throughout. After release, the first cycle starts on the first edge.
2. Single write with defaults, addr=8'h21, data=8'h45 → cs_n low in cycles 1-8 and 11-18, wr_n low in cycles 3-6 and 13-16, bus_out=21 in cycles 1-8 and 45 in cycles 11-18, done in cycle 19, rd_n=1 always.
3. start pulsed in cycle 5 with addr=8'hF1 → ignored. A second start in the first IDLE cycle launches a new write with the new values.
4. Reset asserted in cycle 14 (mid data pulse) → wr_n, cs_n return to 1 and bus_oe to 0 within the same cycle, no done. After release, the block is in IDLE.
5. Parameters T_SETUP=1, T_PULSE=1, T_HOLD=1, T_GAP=1 → total busy length 8 cycles (7 phases + DONE), wr_n low for exactly 1 cycle per phase.
6. start held high continuously for 3 writes → each write separated by exactly one IDLE cycle. Bus check: bus_out stable across every wr_n low interval.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed A/D bus cycle generators.
// Covers state encoding, default phase timing and bus idle levels.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_A_SETUP = 4'd1,
    ST_A_PULSE = 4'd2,
    ST_A_HOLD  = 4'd3,
    ST_GAP     = 4'd4,
    ST_D_SETUP = 4'd5,
    ST_D_PULSE = 4'd6,
    ST_D_HOLD  = 4'd7,
    ST_DONE    = 4'd8
  } rtc_state_e;

  localparam int TIMER_W = 6;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 4;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_GAP   = 2;

  localparam logic CS_IDLE = 1'b1;
  localparam logic WR_IDLE = 1'b1;
  localparam logic RD_IDLE = 1'b1;
  localparam logic AD_ADDR = 1'b0;
  localparam logic AD_DATA = 1'b1;

  function automatic logic timing_ok(input int t);
    return (t >= 1) && (t <= 63);
  endfunction

  // A phase of t cycles loads t-1, because the zero cycle is part of the phase.
  function automatic logic [TIMER_W-1:0] load_of(input int t);
    return TIMER_W'(t - 1);
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable 6-bit down-counter that times each bus phase.
// It stops at zero and flags zero so the FSM knows a phase has run out.
module rtc_phase_timer import rtc_bus_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/rtc_write_cycle.sv
// One RTC register write: address phase, CS gap, then data phase on the A/D bus.
// Every bus output is registered and decoded from the next state.
module rtc_write_cycle import rtc_bus_pkg::*; #(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_GAP   = DEF_T_GAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       busy,
  output logic       done
);

  generate
    if (!timing_ok(T_SETUP) || !timing_ok(T_PULSE) ||
        !timing_ok(T_HOLD)  || !timing_ok(T_GAP)) begin : g_bad_timing
      $error("rtc_write_cycle: timing parameters must lie in 1..63");
    end
  endgenerate

  rtc_state_e         state_q, state_d;
  logic [7:0]         addr_q, data_q;
  logic               accept;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  logic       cs_d, ad_d, wr_d, oe_d, busy_d, done_d;
  logic [7:0] bus_d, addr_sel;

  rtc_phase_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_A_SETUP; accept = 1'b1;
        timer_load = 1'b1; timer_value = load_of(T_SETUP);
      end
      ST_A_SETUP: if (timer_zero) begin
        state_d = ST_A_PULSE; timer_load = 1'b1; timer_value = load_of(T_PULSE);
      end
      ST_A_PULSE: if (timer_zero) begin
        state_d = ST_A_HOLD; timer_load = 1'b1; timer_value = load_of(T_HOLD);
      end
      ST_A_HOLD: if (timer_zero) begin
        state_d = ST_GAP; timer_load = 1'b1; timer_value = load_of(T_GAP);
      end
      ST_GAP: if (timer_zero) begin
        state_d = ST_D_SETUP; timer_load = 1'b1; timer_value = load_of(T_SETUP);
      end
      ST_D_SETUP: if (timer_zero) begin
        state_d = ST_D_PULSE; timer_load = 1'b1; timer_value = load_of(T_PULSE);
      end
      ST_D_PULSE: if (timer_zero) begin
        state_d = ST_D_HOLD; timer_load = 1'b1; timer_value = load_of(T_HOLD);
      end
      ST_D_HOLD: if (timer_zero) begin
        state_d = ST_DONE; timer_load = 1'b1; timer_value = '0;
      end
      ST_DONE: begin
        state_d = ST_IDLE; timer_load = 1'b1; timer_value = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // On the accept edge the latch is still being written, so the bus takes addr directly.
  assign addr_sel = accept ? addr : addr_q;

  always_comb begin
    cs_d   = CS_IDLE;
    ad_d   = AD_DATA;
    wr_d   = WR_IDLE;
    oe_d   = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    bus_d  = bus_out;
    case (state_d)
      ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
        cs_d = 1'b0; ad_d = AD_ADDR; oe_d = 1'b1; bus_d = addr_sel;
        wr_d = (state_d == ST_A_PULSE) ? 1'b0 : WR_IDLE;
      end
      ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
        cs_d = 1'b0; ad_d = AD_DATA; oe_d = 1'b1; bus_d = data_q;
        wr_d = (state_d == ST_D_PULSE) ? 1'b0 : WR_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cs_n    <= CS_IDLE;
      ad_n    <= AD_DATA;
      wr_n    <= WR_IDLE;
      bus_out <= '0;
      bus_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= addr;
        data_q <= data;
      end
      cs_n    <= cs_d;
      ad_n    <= ad_d;
      wr_n    <= wr_d;
      bus_out <= bus_d;
      bus_oe  <= oe_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign rd_n = RD_IDLE;

endmodule
